// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: condition encodings, field widths
// and the per-thread branch entry record.
package branch_resolver_pkg;

    localparam int COND_WIDTH  = 3;
    localparam int BR_PC_WIDTH = 10;

    // Codes 6 and 7 are storable but evaluate as never-taken.
    typedef enum logic [COND_WIDTH-1:0] {
        COND_NEVER    = 3'd0,
        COND_ALWAYS   = 3'd1,
        COND_ZERO     = 3'd2,
        COND_NONZERO  = 3'd3,
        COND_NEGATIVE = 3'd4,
        COND_POSITIVE = 3'd5
    } cond_e;

    // Condition is kept as a raw field so unused codes survive a write.
    typedef struct packed {
        logic                   valid;
        logic [BR_PC_WIDTH-1:0] origin;
        logic [BR_PC_WIDTH-1:0] destination;
        logic [COND_WIDTH-1:0]  condition;
        logic                   cancel;
    } entry_t;

endpackage

// File: rtl/branch_resolver_condition_eval.sv
// Combinational branch condition evaluation against the thread's result flags.
module branch_condition_eval
    import branch_resolver_pkg::*;
(
    input  logic [COND_WIDTH-1:0] condition,
    input  logic                  flag_zero,
    input  logic                  flag_negative,
    output logic                  cond_true
);

    // Decode the condition code; unknown codes never take the branch.
    always_comb begin
        cond_true = 1'b0;
        case (condition)
            COND_NEVER:    cond_true = 1'b0;
            COND_ALWAYS:   cond_true = 1'b1;
            COND_ZERO:     cond_true = flag_zero;
            COND_NONZERO:  cond_true = ~flag_zero;
            COND_NEGATIVE: cond_true = flag_negative;
            COND_POSITIVE: cond_true = ~flag_zero & ~flag_negative;
            default:       cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: per-thread branch table in front of the PC controller.
// Stage 0 matches the issued pc against the current thread's entries,
// stage 1 evaluates the condition, outputs are registered (2-cycle latency).
// Optional macro BRANCH_RESOLVER_TAKEN_COUNT_EN builds the taken-branch counter;
// without it taken_count is constant 0.
// The PC field width of the stored entries comes from the shared package, so
// PC_WIDTH is expected to stay at BR_PC_WIDTH.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int PC_WIDTH           = BR_PC_WIDTH,
    parameter int THREAD_COUNT       = 8,
    parameter int THREAD_COUNT_WIDTH = 3,
    parameter int BRANCH_COUNT       = 4,
    parameter int BRANCH_COUNT_WIDTH = 2,
    parameter int INITIAL_THREAD     = 0
)(
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [PC_WIDTH-1:0]           pc,
    input  logic                          flag_zero,
    input  logic                          flag_negative,
    input  logic                          cfg_wren,
    input  logic [THREAD_COUNT_WIDTH-1:0] cfg_thread,
    input  logic [BRANCH_COUNT_WIDTH-1:0] cfg_entry,
    input  logic                          cfg_valid,
    input  logic [PC_WIDTH-1:0]           cfg_origin,
    input  logic [PC_WIDTH-1:0]           cfg_destination,
    input  logic [COND_WIDTH-1:0]         cfg_condition,
    input  logic                          cfg_cancel,
    output logic                          jump,
    output logic [PC_WIDTH-1:0]           jump_destination,
    output logic                          cancel,
    output logic [31:0]                   taken_count
);

    entry_t                        entries_r [THREAD_COUNT][BRANCH_COUNT];
    logic [THREAD_COUNT_WIDTH-1:0] thread_r;

    logic [BRANCH_COUNT-1:0]       match_s;
    logic [BRANCH_COUNT_WIDTH-1:0] sel_s;
    logic                          hit_s;
    entry_t                        sel_entry_s;

    logic                          s1_hit_r;
    logic [PC_WIDTH-1:0]           s1_dest_r;
    logic [COND_WIDTH-1:0]         s1_cond_r;
    logic                          s1_cancel_r;

    logic                          cond_true_s;
    logic                          taken_s;

    logic                          jump_r;
    logic [PC_WIDTH-1:0]           dest_r;
    logic                          cancel_r;

    // Round-robin thread counter; holds INITIAL_THREAD for the first cycle after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            thread_r <= THREAD_COUNT_WIDTH'(INITIAL_THREAD);
        end else if (thread_r == THREAD_COUNT_WIDTH'(THREAD_COUNT - 1)) begin
            thread_r <= {THREAD_COUNT_WIDTH{1'b0}};
        end else begin
            thread_r <= thread_r + THREAD_COUNT_WIDTH'(1);
        end
    end

    // Entry table; a write commits at the edge so a same-cycle lookup sees old contents.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 0; t < THREAD_COUNT; t++) begin
                for (int e = 0; e < BRANCH_COUNT; e++) begin
                    entries_r[t][e] <= '0;
                end
            end
        end else if (cfg_wren) begin
            entries_r[cfg_thread][cfg_entry] <= '{valid:       cfg_valid,
                                                 origin:      cfg_origin,
                                                 destination: cfg_destination,
                                                 condition:   cfg_condition,
                                                 cancel:      cfg_cancel};
        end
    end

    // Stage 0 lookup: exact origin match on valid entries, lowest index wins.
    always_comb begin
        match_s = {BRANCH_COUNT{1'b0}};
        sel_s   = {BRANCH_COUNT_WIDTH{1'b0}};
        for (int i = 0; i < BRANCH_COUNT; i++) begin
            match_s[i] = entries_r[thread_r][i].valid &&
                         (entries_r[thread_r][i].origin == pc);
        end
        for (int i = BRANCH_COUNT - 1; i >= 0; i--) begin
            sel_s = match_s[i] ? BRANCH_COUNT_WIDTH'(i) : sel_s;
        end
        hit_s       = |match_s;
        sel_entry_s = entries_r[thread_r][sel_s];
    end

    // Stage 1 registers: snapshot of the winning entry, immune to later config writes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_hit_r    <= 1'b0;
            s1_dest_r   <= {PC_WIDTH{1'b0}};
            s1_cond_r   <= {COND_WIDTH{1'b0}};
            s1_cancel_r <= 1'b0;
        end else begin
            s1_hit_r    <= hit_s;
            s1_dest_r   <= sel_entry_s.destination;
            s1_cond_r   <= sel_entry_s.condition;
            s1_cancel_r <= sel_entry_s.cancel;
        end
    end

    branch_condition_eval u_cond_eval (
        .condition     (s1_cond_r),
        .flag_zero     (flag_zero),
        .flag_negative (flag_negative),
        .cond_true     (cond_true_s)
    );

    assign taken_s = s1_hit_r & cond_true_s;

    // Output registers; destination and cancel are zeroed whenever the branch is not taken.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            jump_r   <= 1'b0;
            dest_r   <= {PC_WIDTH{1'b0}};
            cancel_r <= 1'b0;
        end else begin
            jump_r   <= taken_s;
            dest_r   <= taken_s ? s1_dest_r : {PC_WIDTH{1'b0}};
            cancel_r <= taken_s & s1_cancel_r;
        end
    end

    assign jump             = jump_r;
    assign jump_destination = dest_r;
    assign cancel           = cancel_r;

`ifdef BRANCH_RESOLVER_TAKEN_COUNT_EN
    logic [31:0] taken_count_r;

    // Taken counter, advancing on the same edge that registers jump high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            taken_count_r <= 32'd0;
        end else if (taken_s) begin
            taken_count_r <= taken_count_r + 32'd1;
        end
    end

    assign taken_count = taken_count_r;
`else
    assign taken_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: table-driven resolutions plus
// hand-written sequences for pipelining, config timing and reset.
module tb_branch_resolver;

    localparam logic [9:0] IDLE_PC = 10'h3FF;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  pc = IDLE_PC;
    logic        flag_zero = 1'b0;
    logic        flag_negative = 1'b0;
    logic        cfg_wren = 1'b0;
    logic [2:0]  cfg_thread = 3'd0;
    logic [1:0]  cfg_entry = 2'd0;
    logic        cfg_valid = 1'b0;
    logic [9:0]  cfg_origin = 10'd0;
    logic [9:0]  cfg_destination = 10'd0;
    logic [2:0]  cfg_condition = 3'd0;
    logic        cfg_cancel = 1'b0;
    logic        jump;
    logic [9:0]  jump_destination;
    logic        cancel;
    logic [31:0] taken_count;

    int checks = 0;
    int failures = 0;
    int cur_thread = 0;
    int exp_taken = 0;

    always #5 clock = ~clock;

    branch_resolver dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .pc               (pc),
        .flag_zero        (flag_zero),
        .flag_negative    (flag_negative),
        .cfg_wren         (cfg_wren),
        .cfg_thread       (cfg_thread),
        .cfg_entry        (cfg_entry),
        .cfg_valid        (cfg_valid),
        .cfg_origin       (cfg_origin),
        .cfg_destination  (cfg_destination),
        .cfg_condition    (cfg_condition),
        .cfg_cancel       (cfg_cancel),
        .jump             (jump),
        .jump_destination (jump_destination),
        .cancel           (cancel),
        .taken_count      (taken_count)
    );

    typedef struct {
        int         th;
        int         en;
        logic       v;
        logic [9:0] o;
        logic [9:0] d;
        logic [2:0] cond;
        logic       can;
    } cfg_t;

    typedef struct {
        int         th;
        logic [9:0] pc;
        logic       fz;
        logic       fn;
        logic       j;
        logic [9:0] d;
        logic       c;
    } vec_t;

    cfg_t cfgs [8];
    vec_t vecs [15];

    task automatic step();
        @(posedge clock);
        #1;
        cur_thread = (cur_thread + 1) % 8;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ej, input logic [9:0] ed, input logic ec);
        if (ej) exp_taken++;
        check({tag, ".jump"}, 32'(jump), 32'(ej));
        check({tag, ".dest"}, 32'(jump_destination), 32'(ed));
        check({tag, ".cancel"}, 32'(cancel), 32'(ec));
`ifdef BRANCH_RESOLVER_TAKEN_COUNT_EN
        check({tag, ".taken"}, taken_count, 32'(exp_taken));
`else
        check({tag, ".taken"}, taken_count, 32'd0);
`endif
    endtask

    task automatic drive_cfg(input cfg_t c);
        cfg_thread      = 3'(c.th);
        cfg_entry       = 2'(c.en);
        cfg_valid       = c.v;
        cfg_origin      = c.o;
        cfg_destination = c.d;
        cfg_condition   = c.cond;
        cfg_cancel      = c.can;
        cfg_wren        = 1'b1;
    endtask

    task automatic cfg_write(input cfg_t c);
        drive_cfg(c);
        step();
        cfg_wren = 1'b0;
    endtask

    task automatic wait_thread(input int th);
        while (cur_thread != th) step();
    endtask

    task automatic resolve(input string tag, input vec_t v);
        wait_thread(v.th);
        pc = v.pc;
        step();
        pc = IDLE_PC;
        flag_zero = v.fz;
        flag_negative = v.fn;
        step();
        flag_zero = 1'b0;
        flag_negative = 1'b0;
        chk_out(tag, v.j, v.d, v.c);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        cfg_wren = 1'b0;
        pc = IDLE_PC;
        flag_zero = 1'b0;
        flag_negative = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cur_thread = 0;
        exp_taken = 0;
    endtask

    initial begin
        cfgs[0] = '{0, 0, 1'b1, 10'h010, 10'h080, 3'd1, 1'b1};
        cfgs[1] = '{2, 1, 1'b1, 10'h020, 10'h040, 3'd2, 1'b0};
        cfgs[2] = '{3, 1, 1'b1, 10'h030, 10'h100, 3'd1, 1'b0};
        cfgs[3] = '{3, 3, 1'b1, 10'h030, 10'h200, 3'd1, 1'b1};
        cfgs[4] = '{4, 0, 1'b1, 10'h066, 10'h0AA, 3'd5, 1'b1};
        cfgs[5] = '{6, 2, 1'b1, 10'h070, 10'h0F0, 3'd7, 1'b1};
        cfgs[6] = '{1, 0, 1'b1, 10'h011, 10'h0C0, 3'd3, 1'b0};
        cfgs[7] = '{7, 0, 1'b1, 10'h077, 10'h3FE, 3'd4, 1'b1};

        vecs[0]  = '{0, 10'h010, 1'b0, 1'b0, 1'b1, 10'h080, 1'b1};
        vecs[1]  = '{0, 10'h011, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[2]  = '{2, 10'h020, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[3]  = '{2, 10'h020, 1'b1, 1'b0, 1'b1, 10'h040, 1'b0};
        vecs[4]  = '{3, 10'h030, 1'b0, 1'b0, 1'b1, 10'h100, 1'b0};
        vecs[5]  = '{4, 10'h066, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0};
        vecs[6]  = '{4, 10'h066, 1'b0, 1'b0, 1'b1, 10'h0AA, 1'b1};
        vecs[7]  = '{4, 10'h066, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[8]  = '{6, 10'h070, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0};
        vecs[9]  = '{6, 10'h070, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[10] = '{1, 10'h011, 1'b0, 1'b0, 1'b1, 10'h0C0, 1'b0};
        vecs[11] = '{1, 10'h011, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[12] = '{7, 10'h077, 1'b0, 1'b1, 1'b1, 10'h3FE, 1'b1};
        vecs[13] = '{7, 10'h077, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[14] = '{5, 10'h010, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};

        // Reset state
        apply_reset();
        chk_out("reset", 1'b0, 10'h000, 1'b0);

        for (int i = 0; i < 8; i++) cfg_write(cfgs[i]);

        // Table-driven resolutions
        for (int i = 0; i < 15; i++) resolve($sformatf("vec%0d", i), vecs[i]);

        // Back-to-back threads 0 and 1 both taken
        wait_thread(0);
        pc = 10'h010;
        step();
        pc = 10'h011;
        step();
        pc = IDLE_PC;
        chk_out("pipe_t0", 1'b1, 10'h080, 1'b1);
        step();
        chk_out("pipe_t1", 1'b1, 10'h0C0, 1'b0);

        // Config write in the same cycle as the lookup takes effect next period
        wait_thread(5);
        pc = 10'h050;
        drive_cfg('{5, 0, 1'b1, 10'h050, 10'h055, 3'd1, 1'b0});
        step();
        cfg_wren = 1'b0;
        pc = IDLE_PC;
        step();
        chk_out("same_cycle_cfg", 1'b0, 10'h000, 1'b0);
        resolve("after_cfg", '{5, 10'h050, 1'b0, 1'b0, 1'b1, 10'h055, 1'b0});

        // Config write while the thread is in stage 1 leaves that resolution intact
        wait_thread(2);
        pc = 10'h020;
        step();
        pc = IDLE_PC;
        flag_zero = 1'b1;
        drive_cfg('{2, 1, 1'b0, 10'h020, 10'h3AA, 3'd2, 1'b1});
        step();
        cfg_wren = 1'b0;
        flag_zero = 1'b0;
        chk_out("inflight_cfg", 1'b1, 10'h040, 1'b0);
        resolve("disabled_t2", '{2, 10'h020, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0});

        // Disabled lower entry lets the higher duplicate win
        cfg_write('{3, 1, 1'b0, 10'h030, 10'h111, 3'd1, 1'b0});
        resolve("disabled_t3", '{3, 10'h030, 1'b0, 1'b0, 1'b1, 10'h200, 1'b1});

        // Asynchronous reset with one result on the outputs and another in stage 1
        wait_thread(0);
        pc = 10'h010;
        step();
        pc = 10'h011;
        step();
        pc = IDLE_PC;
        chk_out("pre_reset", 1'b1, 10'h080, 1'b1);
        reset_n = 1'b0;
        #2;
        exp_taken = 0;
        chk_out("async_reset", 1'b0, 10'h000, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cur_thread = 0;
        step();
        chk_out("inflight_dropped", 1'b0, 10'h000, 1'b0);
        resolve("post_reset_t0", '{0, 10'h010, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0});
        resolve("post_reset_t1", '{1, 10'h011, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
